pio_input_capture: RTL and testbench
====================================

// Module: pio_input_capture
// PURPOSE
//  Avalon-MM slave input PIO: the input-direction counterpart to the 24-bit output PIO on the QSYS bus.
//  Synchronises and debounces a WIDTH-bit external input bus (switches/keys), latches edges in a
//  software-clearable edge-capture register, and raises a level interrupt gated by a per-bit mask.
// PARAMETERS
//  WIDTH           24     number of input bits (1..32)
//  DEBOUNCE_CYCLES 50000  clk cycles between debounce samples; 0 = debounce bypassed
//  EDGE_TYPE       0      0 = rising, 1 = falling, 2 = any edge captured
// PORTS
//  clk        in   1      system clock; the only clock
//  reset      in   1      synchronous, active-high reset
//  address    in   2      word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe; read = chipselect & write_n
//  writedata  in   32     write data
//  readdata   out  32     registered read data, upper 32-WIDTH bits zero
//  in_port    in   WIDTH  asynchronous external inputs
//  irq        out  1      level interrupt = |(edgecapture & irqmask)
// BEHAVIOUR
//  Reset: readdata=0, irqmask=0, edgecapture=0, sync stages=0, debounced=0, prescaler=0, primed=0, irq=0.
//  Sync: two flops per bit on in_port; no combinational path from in_port.
//  Prescaler: counts 0..DEBOUNCE_CYCLES-1; tick = 1 cycle when count wraps to 0 (first tick DEBOUNCE_CYCLES
//   cycles after reset release). DEBOUNCE_CYCLES=0: tick every cycle, debounced = sync output directly.
//  Debounce: on tick, sample[i] <= sync[i]; debounced[i] <= sync[i] only if sync[i]==sample[i]
//   (two consecutive tick samples agree). Latency in->debounced: 2 sync + up to 2 tick periods.
//  Primed: first tick after reset loads sample and debounced from sync directly, sets primed=1, and
//   suppresses edge detection; no spurious capture for inputs held high through reset.
//  Edge: when primed, detected per bit on debounced change (prev vs new) per EDGE_TYPE; event sets
//   edgecapture[i] on the cycle debounced updates.
//  Reads (chipselect & write_n): readdata <= mux(address) next cycle (read latency 1);
//   address 1 reads 0; readdata holds last value when not reading.
//  Writes (chipselect & ~write_n): addr 2 irqmask <= writedata[WIDTH-1:0]; addr 3 write-1-to-clear:
//   edgecapture &= ~writedata; addr 0/1 ignored.
//  Simultaneous capture and W1C on same bit: set wins (bit stays 1); other bits clear normally.
//  irq combinational from irqmask/edgecapture registers; deasserts the cycle after the clearing write.
//  Reset mid-debounce: all state returns to reset values; prescaler restarts from 0, primed=0.
// STRUCTURE
//  Shared package: address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and EDGE_* encodings,
//   shared with the output PIO.
//  One sub-module: pio_debounce_tick (prescaler producing tick; bypass when DEBOUNCE_CYCLES=0).
//  Remainder (sync, debounce, edge, regs, read mux) inline.
// TESTING
//  Reset hold: in_port=24'hFFFFFF through reset, DEBOUNCE_CYCLES=4 -> after priming data reads
//   24'hFFFFFF, edgecapture=0, irq=0.
//  Rising capture: in_port bit3 0->1 stable, irqmask=8 -> edgecapture=32'h8 within 2+2*4 cycles,
//   irq=1; write 32'h8 to addr 3 -> edgecapture=0, irq=0 next cycle.
//  Bounce reject: toggle bit0 every 3 cycles with DEBOUNCE_CYCLES=4 -> debounced bit0 never changes,
//   edgecapture bit0 stays 0.
//  Set-vs-clear race: W1C of bit5 on the same cycle bit5 capture fires -> edgecapture[5]=1 after the write.
//  Register map: write 32'hFFFFFFFF to addr 2 -> readback 32'h00FFFFFF; write addr 0 -> no effect;
//   read addr 1 -> 0; read data valid exactly 1 cycle after select.
//  EDGE_TYPE=2, DEBOUNCE_CYCLES=0: bit7 pulse 1 then 0 -> captured on rise, clear, re-captured on fall.

Source files
------------

// File: rtl/pio_input_capture_pkg.sv
// Shared definitions for the QSYS parallel I/O blocks: register map and edge encodings.
package pio_input_capture_pkg;

    // Word addresses of the slave register map.
    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    // Edge-capture selection values.
    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Per-bit edge events between a previous and a new level vector.
    function automatic logic [31:0] edge_events(input logic [31:0] prev_lvl,
                                                input logic [31:0] next_lvl,
                                                input int unsigned edge_type);
        logic [31:0] ev;
        case (edge_type)
            EDGE_RISING:  ev = next_lvl & ~prev_lvl;
            EDGE_FALLING: ev = ~next_lvl & prev_lvl;
            EDGE_ANY:     ev = next_lvl ^ prev_lvl;
            default:      ev = '0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/pio_debounce_tick.sv
// Debounce prescaler: one-cycle tick every DEBOUNCE_CYCLES clocks, first tick
// DEBOUNCE_CYCLES cycles after reset release. DEBOUNCE_CYCLES=0 ticks every cycle.
module pio_debounce_tick #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    // With 0 or 1 the counter degenerates to a constant zero and tick is always high.
    localparam int unsigned LAST_VAL = (DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1;
    localparam int unsigned CW       = (LAST_VAL > 0) ? $clog2(LAST_VAL + 1) : 1;
    localparam logic [CW-1:0] LAST   = CW'(LAST_VAL);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap to zero after the last value.
    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    // Prescaler counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Tick marks the edge on which the count wraps to zero.
    assign tick = (count_q == LAST);

endmodule

// File: rtl/pio_input_capture.sv
// Avalon-MM input PIO: synchronises and debounces in_port, captures edges into a
// write-1-to-clear register and raises a masked level interrupt.
module pio_input_capture
    import pio_input_capture_pkg::*;
#(
    parameter int unsigned WIDTH           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic             tick;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic             primed_q, primed_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] agree;
    logic             bus_rd;
    logic             bus_wr;
    logic             unused_wdata;

    pio_debounce_tick #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign bus_rd = chipselect & write_n;
    assign bus_wr = chipselect & ~write_n;

    // Bits above WIDTH of the write bus carry no register state.
    assign unused_wdata = ^writedata;

    // Input path: two-flop synchroniser, tick-sampled debounce, priming and edge events.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        sample_d = sample_q;
        deb_d    = deb_q;
        primed_d = primed_q;
        events   = '0;
        agree    = ~(sync2_q ^ sample_q);
        if (tick) begin
            sample_d = sync2_q;
            if (!primed_q) begin
                // First tick adopts the current level silently so a held input is not an edge.
                deb_d    = sync2_q;
                primed_d = 1'b1;
            end else begin
                if (DEBOUNCE_CYCLES == 0) begin
                    deb_d = sync2_q;
                end else begin
                    // A bit follows the input only when two consecutive tick samples agree.
                    deb_d = (sync2_q & agree) | (deb_q & ~agree);
                end
                events = WIDTH'(edge_events(32'(deb_q), 32'(deb_d), EDGE_TYPE));
            end
        end
    end

    // Register file: mask write, write-1-to-clear capture (a new event wins), read mux.
    always_comb begin
        irqmask_d  = irqmask_q;
        edgecap_d  = edgecap_q;
        readdata_d = readdata_q;
        if (bus_wr) begin
            case (pio_addr_e'(address))
                ADDR_IRQMASK: irqmask_d = writedata[WIDTH-1:0];
                ADDR_EDGECAP: edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
                default:      ;
            endcase
        end
        edgecap_d = edgecap_d | events;
        if (bus_rd) begin
            case (pio_addr_e'(address))
                ADDR_DATA:    readdata_d = 32'(deb_q);
                ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
                ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
                default:      readdata_d = '0;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sample_q   <= '0;
            deb_q      <= '0;
            primed_q   <= 1'b0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sample_q   <= sample_d;
            deb_q      <= deb_d;
            primed_q   <= primed_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_input_capture.sv
// Bench for pio_input_capture: instance A (debounce 4, rising) and instance B
// (debounce bypassed, any edge) share one bus and are checked against a history model.
module tb_pio_input_capture;
    import pio_input_capture_pkg::*;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_a, in_b;
    logic [31:0]   rd_a, rd_b;
    logic          irq_a, irq_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pio_input_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISING)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a)
    );

    pio_input_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_ANY)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b)
    );

    // Reference model: in_d2 is the input seen two edges ago (what the synchroniser delivers);
    // debounce adopts a sample only when it matches the previous tick's sample.
    typedef struct {
        int unsigned  cyc;
        logic         primed;
        logic [W-1:0] in_d1, in_d2, last, deb, mask, ecap;
        logic [31:0]  rd;
    } model_t;

    model_t ma, mb;

    function automatic void model_step(inout model_t m, input logic [W-1:0] pin,
                                       input int unsigned n, input int unsigned et);
        logic [W-1:0] sv, nd, ev, agree;
        bit tick;
        if (reset) begin
            m.cyc = 0; m.primed = 1'b0; m.in_d1 = '0; m.in_d2 = '0; m.last = '0;
            m.deb = '0; m.mask = '0; m.ecap = '0; m.rd = '0;
            return;
        end
        if (chipselect && write_n) begin
            case (address)
                2'd0:    m.rd = 32'(m.deb);
                2'd2:    m.rd = 32'(m.mask);
                2'd3:    m.rd = 32'(m.ecap);
                default: m.rd = 32'h0;
            endcase
        end
        m.cyc++;
        sv = m.in_d2;
        m.in_d2 = m.in_d1;
        m.in_d1 = pin;
        tick = (n == 0) || (m.cyc % n == 0);
        ev = '0;
        if (tick) begin
            if (!m.primed) begin
                m.deb = sv;
                m.primed = 1'b1;
            end else begin
                agree = ~(sv ^ m.last);
                nd = (n == 0) ? sv : ((sv & agree) | (m.deb & ~agree));
                case (et)
                    0:       ev = nd & ~m.deb;
                    1:       ev = ~nd & m.deb;
                    default: ev = nd ^ m.deb;
                endcase
                m.deb = nd;
            end
            m.last = sv;
        end
        if (chipselect && !write_n) begin
            if (address == 2'd2) m.mask = writedata[W-1:0];
            if (address == 2'd3) m.ecap = m.ecap & ~writedata[W-1:0];
        end
        m.ecap = m.ecap | ev;
    endfunction

    always @(posedge clk) begin
        model_step(ma, in_a, 4, 0);
        model_step(mb, in_b, 0, 2);
    end

    task automatic idle();
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        idle();
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        idle();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_a = '1; in_b = '0; idle();
        wait_cycles(3);
        n_checks++; if (rd_a !== 32'h0) $display("FAIL reset_readdata: got %h want %h", rd_a, 32'h0); else n_pass++;
        n_checks++; if (irq_a !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_a); else n_pass++;
        reset = 1'b0;
        wait_cycles(8);
        bus_read(ADDR_DATA);
        n_checks++; if (rd_a !== 32'h00FFFFFF) $display("FAIL hold_data: got %h want %h", rd_a, 32'h00FFFFFF); else n_pass++;
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_a !== 32'h0) $display("FAIL hold_edgecap: got %h want %h", rd_a, 32'h0); else n_pass++;
        n_checks++; if (irq_a !== 1'b0) $display("FAIL hold_irq: got %b want 0", irq_a); else n_pass++;
    endtask

    task automatic test_rising();
        int  k;
        bit  seen;
        in_a = '0;
        wait_cycles(16);
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_a !== 32'h0) $display("FAIL falling_ignored: got %h want %h", rd_a, 32'h0); else n_pass++;
        bus_write(ADDR_IRQMASK, 32'h8);
        in_a = 24'h8;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (irq_a) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen || k > 10) $display("FAIL rising_latency: irq after %0d cycles (seen=%0d) want <=10", k, seen); else n_pass++;
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_a !== 32'h8) $display("FAIL rising_edgecap: got %h want %h", rd_a, 32'h8); else n_pass++;
        n_checks++; if (irq_a !== 1'b1) $display("FAIL rising_irq: got %b want 1", irq_a); else n_pass++;
        bus_write(ADDR_EDGECAP, 32'h8);
        n_checks++; if (irq_a !== 1'b0) $display("FAIL w1c_irq: got %b want 0", irq_a); else n_pass++;
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_a !== 32'h0) $display("FAIL w1c_edgecap: got %h want %h", rd_a, 32'h0); else n_pass++;
    endtask

    task automatic test_bounce();
        // Align so the toggle pattern starts on an even cycle count: then the
        // high phase is never seen on two consecutive ticks.
        while (ma.cyc % 2 == 0) @(negedge clk);
        for (int k = 0; k < 60; k++) begin
            in_a[0] = ((k / 3) % 2) == 1;
            chipselect = 1'b1; write_n = 1'b1; address = ADDR_DATA;
            @(negedge clk);
            n_checks++; if (rd_a[0] !== 1'b0) $display("FAIL bounce_data k=%0d: got %b want 0", k, rd_a[0]); else n_pass++;
        end
        in_a[0] = 1'b0;
        idle();
        wait_cycles(12);
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_a !== 32'h0) $display("FAIL bounce_edgecap: got %h want %h", rd_a, 32'h0); else n_pass++;
    endtask

    task automatic test_regmap();
        bus_write(ADDR_IRQMASK, 32'hFFFFFFFF);
        bus_read(ADDR_RSVD);
        n_checks++; if (rd_a !== 32'h0) $display("FAIL rsvd_read: got %h want %h", rd_a, 32'h0); else n_pass++;
        chipselect = 1'b1; write_n = 1'b1; address = ADDR_IRQMASK;
        @(negedge clk);
        idle();
        n_checks++; if (rd_a !== 32'h00FFFFFF) $display("FAIL mask_read_latency: got %h want %h", rd_a, 32'h00FFFFFF); else n_pass++;
        @(negedge clk);
        n_checks++; if (rd_b !== 32'h00FFFFFF) $display("FAIL readdata_hold: got %h want %h", rd_b, 32'h00FFFFFF); else n_pass++;
        bus_write(ADDR_DATA, 32'h12345678);
        bus_write(ADDR_RSVD, 32'hA5A5A5A5);
        bus_read(ADDR_DATA);
        n_checks++; if (rd_a !== 32'h8) $display("FAIL data_write_ignored: got %h want %h", rd_a, 32'h8); else n_pass++;
        n_checks++; if (rd_b !== 32'h0) $display("FAIL data_b: got %h want %h", rd_b, 32'h0); else n_pass++;
        bus_read(ADDR_IRQMASK);
        n_checks++; if (rd_a !== 32'h00FFFFFF) $display("FAIL rsvd_write_ignored: got %h want %h", rd_a, 32'h00FFFFFF); else n_pass++;
    endtask

    task automatic test_race();
        in_b[1] = 1'b1;
        wait_cycles(4);
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_b !== 32'h2) $display("FAIL race_pre: got %h want %h", rd_b, 32'h2); else n_pass++;
        // Bypass mode: a change seen at edge c reaches debounced at edge c+2.
        in_b[5] = 1'b1;
        wait_cycles(2);
        bus_write(ADDR_EDGECAP, 32'h22);
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_b !== 32'h20) $display("FAIL race_set_wins: got %h want %h", rd_b, 32'h20); else n_pass++;
        n_checks++; if (irq_b !== 1'b1) $display("FAIL race_irq: got %b want 1", irq_b); else n_pass++;
    endtask

    task automatic test_edge_any();
        bus_write(ADDR_EDGECAP, 32'hFFFFFFFF);
        n_checks++; if (irq_b !== 1'b0) $display("FAIL any_clear_irq: got %b want 0", irq_b); else n_pass++;
        in_b[7] = 1'b1;
        wait_cycles(4);
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_b !== 32'h80) $display("FAIL any_rise: got %h want %h", rd_b, 32'h80); else n_pass++;
        bus_write(ADDR_EDGECAP, 32'h80);
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_b !== 32'h0) $display("FAIL any_cleared: got %h want %h", rd_b, 32'h0); else n_pass++;
        in_b[7] = 1'b0;
        wait_cycles(4);
        bus_read(ADDR_EDGECAP);
        n_checks++; if (rd_b !== 32'h80) $display("FAIL any_fall: got %h want %h", rd_b, 32'h80); else n_pass++;
        n_checks++; if (irq_b !== 1'b1) $display("FAIL any_irq: got %b want 1", irq_b); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        in_a = W'($urandom);
        wait_cycles(3);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (rd_a !== 32'h0 || rd_b !== 32'h0) $display("FAIL mid_reset_rd: got %h/%h want 0", rd_a, rd_b); else n_pass++;
        n_checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) $display("FAIL mid_reset_irq: got %b/%b want 0", irq_a, irq_b); else n_pass++;
        in_a = '1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chipselect = 1'b1; write_n = 1'b1; address = ADDR_DATA;
            @(negedge clk);
            exp = (k >= 5) ? 32'h00FFFFFF : 32'h0;
            n_checks++; if (rd_a !== exp) $display("FAIL restart_tick k=%0d: got %h want %h", k, rd_a, exp); else n_pass++;
        end
        bus_read(ADDR_IRQMASK);
        n_checks++; if (rd_a !== 32'h0) $display("FAIL mid_reset_mask: got %h want %h", rd_a, 32'h0); else n_pass++;
    endtask

    task automatic test_random(input int cycles);
        int unsigned op;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(99) < 8) in_a = in_a ^ (W'($urandom) & W'($urandom) & W'($urandom));
            if ($urandom_range(99) < 5) in_b = in_b ^ (W'($urandom) & W'($urandom));
            op = $urandom_range(9);
            idle();
            if (op <= 4) begin
                chipselect = 1'b1; write_n = 1'b1; address = 2'($urandom_range(3));
            end else if (op <= 7) begin
                chipselect = 1'b1; write_n = 1'b0;
                address = (op == 5) ? 2'd2 : (op == 6) ? 2'd3 : 2'($urandom_range(3));
                writedata = $urandom;
            end
            @(negedge clk);
            n_checks++; if (rd_a !== ma.rd) $display("FAIL rand_rd_a c=%0d: got %h want %h", c, rd_a, ma.rd); else n_pass++;
            n_checks++; if (rd_b !== mb.rd) $display("FAIL rand_rd_b c=%0d: got %h want %h", c, rd_b, mb.rd); else n_pass++;
            n_checks++; if (irq_a !== |(ma.ecap & ma.mask)) $display("FAIL rand_irq_a c=%0d: got %b want %b", c, irq_a, |(ma.ecap & ma.mask)); else n_pass++;
            n_checks++; if (irq_b !== |(mb.ecap & mb.mask)) $display("FAIL rand_irq_b c=%0d: got %b want %b", c, irq_b, |(mb.ecap & mb.mask)); else n_pass++;
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        in_a = '0;
        in_b = '0;
        idle();
        @(negedge clk);
        test_reset();
        test_rising();
        test_bounce();
        test_regmap();
        test_race();
        test_edge_any();
        test_reset_mid();
        test_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
